keypad_scanner_param: RTL

- Parametrised matrix-keypad scanner; successor to the fixed 4x4 hex-keypad controller.
- Contains its own 2-flop row synchronizer, so it connects directly to raw keypad row lines.
- Drives column strobes and decodes a single pressed key into a binary code.
- Adds debounce, multi-key (ghost) rejection and optional auto-repeat; sits between the keypad pins and the host logic.

---
 rtl/keypad_scanner_param.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner_param.sv
// keypad_scanner_param
// Scans a ROWS x COLS matrix keypad and reports one pressed key as a
// binary code. It debounces presses and releases, rejects multi-key
// (ghost) patterns, and can optionally auto-repeat a held key.
//
// Ports
//   clock     : rising-edge system clock
//   reset     : asynchronous active-low reset
//   row       : raw, asynchronous row lines (high = contact on a driven column)
//   col       : column drive (all ones while idle/releasing, one-hot otherwise)
//   code      : row_index*COLS + col_index of the accepted key; held between presses
//   valid     : one-cycle strobe, code is new (first press or a repeat)
//   held      : high while an accepted key stays pressed
//   multi     : one-cycle strobe, more than one key seen
//   state_dbg : current FSM state, for observation only
//
// Output handshake: valid and multi are one-cycle strobes with no ready/backpressure;
// the host must capture code in the cycle valid is high. They are never high together.

module keypad_scanner_param #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int CODE_W     = $clog2(ROWS*COLS),
    parameter int SETTLE     = 3,
    parameter int DEBOUNCE   = 4,
    parameter int REPEAT_EN  = 0,
    parameter int REPEAT_DLY = 32,
    parameter int REPEAT_PER = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic              held,
    output logic              multi,
    output logic [2:0]        state_dbg
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SCAN     = 3'd1;
    localparam logic [2:0] DEBOUNCE_ST = 3'd2;
    localparam logic [2:0] PRESSED  = 3'd3;
    localparam logic [2:0] RELEASE  = 3'd4;

    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_MAX = (SETTLE > DEBOUNCE + 1) ? SETTLE : DEBOUNCE + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [2:0]        state;
    logic [ROWS-1:0]   sync1;
    logic [ROWS-1:0]   srow;
    logic [CW-1:0]     col_idx;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        hit_cnt;     // saturates at 2: "more than one"
    logic              multi_flag;
    logic [RW-1:0]     hit_row;
    logic [CW-1:0]     hit_col;
    logic [REP_W-1:0]  rep_cnt;
    logic              rep_first;

    logic              srow_any;
    logic              srow_multi;
    logic [RW-1:0]     srow_idx;
    logic [ROWS-1:0]   hit_onehot;
    logic [CODE_W-1:0] code_calc;
    logic              scan_sample;
    logic              last_col;
    logic [1:0]        pass_hits;
    logic              pass_multi;
    logic [REP_W-1:0]  rep_target;

    // Two-flop synchronizer on the raw row lines; everything below uses srow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            srow  <= '0;
        end else begin
            sync1 <= row;
            srow  <= sync1;
        end
    end

    assign srow_any   = |srow;
    assign srow_multi = |(srow & (srow - ROWS'(1)));   // more than one bit set
    assign hit_onehot = ROWS'(1) << hit_row;
    assign code_calc  = CODE_W'(hit_row) * CODE_W'(COLS) + CODE_W'(hit_col);

    // Lowest set row bit of the current sample.
    always_comb begin
        srow_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (srow[i]) srow_idx = RW'(i);
        end
    end

    // Each column is driven for SETTLE cycles, then sampled on the next one.
    assign scan_sample = (cnt == CNT_W'(SETTLE));
    assign last_col    = (col_idx == CW'(COLS - 1));

    // Pass totals including the sample being taken this cycle.
    assign pass_hits  = !srow_any ? hit_cnt : ((hit_cnt == 2'd2) ? 2'd2 : hit_cnt + 2'd1);
    assign pass_multi = multi_flag || (srow_any && srow_multi) || (pass_hits == 2'd2);

    assign rep_target = rep_first ? REP_W'(REPEAT_DLY - 1) : REP_W'(REPEAT_PER - 1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            col_idx    <= '0;
            cnt        <= '0;
            hit_cnt    <= '0;
            multi_flag <= 1'b0;
            hit_row    <= '0;
            hit_col    <= '0;
            rep_cnt    <= '0;
            rep_first  <= 1'b0;
            code       <= '0;
            valid      <= 1'b0;
            held       <= 1'b0;
            multi      <= 1'b0;
        end else begin
            valid <= 1'b0;
            multi <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (srow_any) begin
                        state      <= SCAN;
                        col_idx    <= '0;
                        hit_cnt    <= '0;
                        multi_flag <= 1'b0;
                    end
                end

                SCAN: begin
                    if (!scan_sample) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt     <= '0;
                        hit_cnt <= pass_hits;
                        if (srow_any && hit_cnt == 2'd0) begin
                            hit_row <= srow_idx;
                            hit_col <= col_idx;
                        end
                        if (srow_any && srow_multi) multi_flag <= 1'b1;
                        if (last_col) begin
                            col_idx <= '0;
                            if (pass_hits == 2'd0) begin
                                state <= IDLE;             // spurious wake
                            end else if (pass_multi) begin
                                multi <= 1'b1;
                                state <= RELEASE;
                            end else begin
                                state <= DEBOUNCE_ST;
                            end
                        end else begin
                            col_idx <= col_idx + CW'(1);
                        end
                    end
                end

                // The first two cycles are skipped: srow still reflects the
                // column driven at the end of the scan pass.
                DEBOUNCE_ST: begin
                    if (cnt < CNT_W'(2)) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (srow != hit_onehot) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == CNT_W'(DEBOUNCE + 1)) begin
                        cnt       <= '0;
                        code      <= code_calc;
                        valid     <= 1'b1;
                        held      <= 1'b1;
                        rep_cnt   <= '0;
                        rep_first <= 1'b1;
                        state     <= PRESSED;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                PRESSED: begin
                    if (!srow_any) begin
                        if (cnt == CNT_W'(DEBOUNCE - 1)) begin
                            cnt   <= '0;
                            held  <= 1'b0;
                            state <= RELEASE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (srow != hit_onehot) begin
                        cnt   <= '0;
                        multi <= 1'b1;
                        held  <= 1'b0;
                        state <= RELEASE;
                    end else begin
                        cnt <= '0;
                        // Repeat only advances while the accepted key is seen.
                        if (REPEAT_EN != 0) begin
                            if (rep_cnt == rep_target) begin
                                valid     <= 1'b1;
                                rep_cnt   <= '0;
                                rep_first <= 1'b0;
                            end else begin
                                rep_cnt <= rep_cnt + REP_W'(1);
                            end
                        end
                    end
                end

                RELEASE: begin
                    if (srow_any) begin
                        cnt <= '0;
                    end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        col = '1;
        case (state)
            SCAN:                 col = COLS'(1) << col_idx;
            DEBOUNCE_ST, PRESSED: col = COLS'(1) << hit_col;
            default:              col = '1;
        endcase
    end

    assign state_dbg = state;

endmodule
